// File: rtl/cb_cfg_pkg.sv
// Shared types and elaboration-time helpers for the connection-box config loader.
// Holds the loader state encoding and the select-width / word-count derivations.
package cb_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StCommit = 2'd2
    } cfg_state_e;

    function automatic int unsigned sel_width(input int unsigned mux_size);
        return (mux_size > 1) ? $clog2(mux_size) : 1;
    endfunction

    function automatic int unsigned num_words(input int unsigned cfg_bits,
                                              input int unsigned cfg_w);
        return (cfg_bits + cfg_w - 1) / cfg_w;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cb_cfg_loader.sv
// Word-serial configuration loader: shifts words into a shadow register and
// copies them to the active register in a single commit cycle.
module cb_cfg_loader
    import cb_cfg_pkg::*;
#(
    parameter int unsigned CFG_W    = 8,
    parameter int unsigned CFG_BITS = 54,
    parameter int unsigned NWORDS   = 7
) (
    input  logic                prog_clk_i,
    input  logic                preset_i,
    input  logic                cfg_start_i,
    input  logic                cfg_abort_i,
    input  logic [CFG_W-1:0]    cfg_data_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    output logic                cfg_busy_o,
    output logic                cfg_done_o,
    output logic [CFG_BITS-1:0] active_cfg_o
);

    localparam int unsigned SHADOW_W = NWORDS * CFG_W;
    localparam int unsigned CNT_W    = cnt_width(NWORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    cfg_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        cfg_ready_o = 1'b0;
        cfg_busy_o  = 1'b0;
        cfg_done_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_start_i) begin
                    state_d  = StLoad;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            StLoad: begin
                cfg_ready_o = 1'b1;
                cfg_busy_o  = 1'b1;
                // Abort beats a coincident final handshake: nothing is captured.
                if (cfg_abort_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cfg_valid_i) begin
                    shadow_d = (shadow_q << CFG_W) | SHADOW_W'(cfg_data_i);
                    if (cnt_q == LAST_WORD) begin
                        state_d = StCommit;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StCommit: begin
                cfg_busy_o = 1'b1;
                cfg_done_o = 1'b1;
                // Low bits only: the padding at the top of the first word is dropped.
                active_d   = shadow_q[CFG_BITS-1:0];
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge prog_clk_i) begin
        if (preset_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active_cfg_o = active_q;

endmodule

// File: rtl/cbx_param_cfg.sv
// Horizontal connection box: channel feed-throughs plus a bank of ipin muxes
// whose selects come from the serially loaded active configuration.
module cbx_param_cfg
    import cb_cfg_pkg::*;
#(
    parameter int unsigned CHAN_W     = 20,
    parameter int unsigned N_TOP      = 10,
    parameter int unsigned N_BOT      = 8,
    parameter int unsigned MUX_SIZE   = 8,
    parameter int unsigned TRACK_STEP = 6,
    parameter int unsigned CFG_W      = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic [CHAN_W-1:0] chanx_left_in,
    input  logic [CHAN_W-1:0] chanx_right_in,
    output logic [CHAN_W-1:0] chanx_left_out,
    output logic [CHAN_W-1:0] chanx_right_out,
    output logic [N_TOP-1:0]  grid_top_out,
    output logic [N_BOT-1:0]  grid_bottom_outpad,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [CFG_W-1:0]  cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              cfg_busy,
    output logic              cfg_done
);

    localparam int unsigned SEL_W    = sel_width(MUX_SIZE);
    localparam int unsigned NMUX     = N_TOP + N_BOT;
    localparam int unsigned CFG_BITS = NMUX * SEL_W;
    localparam int unsigned NWORDS   = num_words(CFG_BITS, CFG_W);
    localparam int unsigned TAPS_N   = 1 << SEL_W;

    logic [CFG_BITS-1:0] active_cfg;
    logic [NMUX-1:0]     mux_out;

    cb_cfg_loader #(
        .CFG_W    (CFG_W),
        .CFG_BITS (CFG_BITS),
        .NWORDS   (NWORDS)
    ) u_loader (
        .prog_clk_i   (prog_clk),
        .preset_i     (pReset),
        .cfg_start_i  (cfg_start),
        .cfg_abort_i  (cfg_abort),
        .cfg_data_i   (cfg_data),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_busy_o   (cfg_busy),
        .cfg_done_o   (cfg_done),
        .active_cfg_o (active_cfg)
    );

    assign chanx_right_out = chanx_left_in;
    assign chanx_left_out  = chanx_right_in;

    for (genvar g = 0; g < NMUX; g++) begin : g_mux
        logic [TAPS_N-1:0] taps;
        logic [SEL_W-1:0]  sel;

        assign sel = active_cfg[g*SEL_W +: SEL_W];

        for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_tap
            localparam int unsigned T = (g + j * TRACK_STEP) % CHAN_W;
            assign taps[2*j]   = chanx_left_in[T];
            assign taps[2*j+1] = chanx_right_in[T];
        end

        // Unused select codes read a tied-low tap.
        if (TAPS_N > MUX_SIZE) begin : g_pad
            assign taps[TAPS_N-1:MUX_SIZE] = '0;
        end

        assign mux_out[g] = taps[sel];
    end

    assign grid_top_out       = mux_out[N_TOP-1:0];
    assign grid_bottom_outpad = mux_out[NMUX-1:N_TOP];

endmodule
